// File: rtl/dcler8_timer.sv
// Registered loadable down-counter / interval timer with one-shot and auto-reload
// modes, a cascade borrow-in and a combinational borrow-out for chaining stages.
module dcler8_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_en,
    input  logic             i_cin,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_count,
    output logic             o_bout,
    output logic             o_expired,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic             r_expired;
    logic             w_expired_nxt;
    logic             w_step;
    logic             w_term;

    assign w_step = i_en & i_cin;
    // Terminal step: counting while already at zero; this is also the borrow to the next stage.
    assign w_term = (r_state == ST_RUN) & w_step & (r_count == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_reload  <= w_reload_nxt;
            r_expired <= w_expired_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_reload_nxt  = r_reload;
        w_expired_nxt = 1'b0;
        if (i_clr) begin
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
        end else if (i_load) begin
            w_count_nxt  = i_load_val;
            w_reload_nxt = i_load_val;
            w_state_nxt  = ST_IDLE;
        end else if (i_start && (r_state != ST_RUN)) begin
            w_state_nxt = ST_RUN;
        end else if (w_term) begin
            w_expired_nxt = 1'b1;
            // mode is looked at here, on every terminal step, not captured at start
            if (i_mode) begin
                w_count_nxt = r_reload;
            end else begin
                w_state_nxt = ST_DONE;
            end
        end else if ((r_state == ST_RUN) && w_step) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_bout    = w_term;
    assign o_expired = r_expired;
    assign o_busy    = (r_state == ST_RUN);

endmodule

// File: tb/tb_dcler8_timer.sv
// Bench for dcler8_timer: two cascaded instances checked every cycle against a
// behavioural timer model, plus hand-computed expectations for directed scenarios.
module tb_dcler8_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 0, load = 0, start = 0, en = 0, cin = 0, mode = 0;
    logic [7:0] lv = 8'd0;
    logic       h_clr = 0, h_load = 0, h_start = 0, h_en = 0, h_mode = 0;
    logic [7:0] h_lv = 8'd0;
    logic [7:0] count, h_count;
    logic       bout, expired, busy, h_bout, h_expired, h_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dcler8_timer #(.WIDTH(8)) u_lo (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_load(load), .i_load_val(lv),
        .i_start(start), .i_en(en), .i_cin(cin), .i_mode(mode),
        .o_count(count), .o_bout(bout), .o_expired(expired), .o_busy(busy));

    dcler8_timer #(.WIDTH(8)) u_hi (
        .i_clk(clk), .i_rst_n(rst_n), .i_clr(h_clr), .i_load(h_load), .i_load_val(h_lv),
        .i_start(h_start), .i_en(h_en), .i_cin(bout), .i_mode(h_mode),
        .o_count(h_count), .o_bout(h_bout), .o_expired(h_expired), .o_busy(h_busy));

    // Behavioural model: st 0=idle, 1=running, 2=done
    typedef struct {
        int cnt;
        int rel;
        int st;
        bit exp;
    } ms_t;

    ms_t mlo, mhi;

    function automatic bit m_bout(ms_t s, bit e, bit c);
        return (s.st == 1) && e && c && (s.cnt == 0);
    endfunction

    function automatic ms_t m_next(ms_t s, bit c_clr, bit c_load, int c_lv, bit c_start,
                                   bit e, bit c, bit md);
        ms_t n = s;
        n.exp = 0;
        if (c_clr) begin
            n.cnt = 0; n.st = 0;
        end else if (c_load) begin
            n.cnt = c_lv; n.rel = c_lv; n.st = 0;
        end else if (c_start && s.st != 1) begin
            n.st = 1;
        end else if (s.st == 1 && e && c) begin
            if (s.cnt == 0) begin
                n.exp = 1;
                if (md) n.cnt = s.rel;
                else    n.st = 2;
            end else begin
                n.cnt = (s.cnt + 255) % 256;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mlo = '{0, 0, 0, 0};
            mhi = '{0, 0, 0, 0};
        end else begin
            bit lb;
            lb  = m_bout(mlo, en, cin);
            mhi = m_next(mhi, h_clr, h_load, int'(h_lv), h_start, h_en, lb, h_mode);
            mlo = m_next(mlo, clr, load, int'(lv), start, en, cin, mode);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle compare of both stages against the model, away from the active edge
    always @(negedge clk) begin
        bit lb;
        lb = m_bout(mlo, en, cin);
        chk("lo.count",   int'(count),   mlo.cnt);
        chk("lo.busy",    int'(busy),    int'(mlo.st == 1));
        chk("lo.expired", int'(expired), int'(mlo.exp));
        chk("lo.bout",    int'(bout),    int'(lb));
        chk("hi.count",   int'(h_count),   mhi.cnt);
        chk("hi.busy",    int'(h_busy),    int'(mhi.st == 1));
        chk("hi.expired", int'(h_expired), int'(mhi.exp));
        chk("hi.bout",    int'(h_bout),    int'(m_bout(mhi, h_en, lb)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        clr = 0; load = 0; start = 0; en = 0; cin = 1;
    endtask

    task automatic do_load(input logic [7:0] v, input logic md);
        idle_in(); load = 1; lv = v; mode = md; tick();
        load = 0; start = 1; tick();
        start = 0;
    endtask

    initial begin
        idle_in();
        #2;
        chk("rst.count", int'(count), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.bout", int'(bout), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // one-shot from 3
        do_load(8'd3, 1'b0);
        chk("os.busy", int'(busy), 1);
        chk("os.start_cnt", int'(count), 3);
        en = 1;
        tick(); chk("os.c1", int'(count), 2);
        tick(); chk("os.c2", int'(count), 1);
        tick(); chk("os.c3", int'(count), 0);
        #1 chk("os.bout", int'(bout), 1);
        tick();
        chk("os.exp", int'(expired), 1);
        chk("os.done_busy", int'(busy), 0);
        chk("os.done_cnt", int'(count), 0);
        en = 0; tick();
        chk("os.exp_off", int'(expired), 0);

        // auto-reload from 2
        do_load(8'd2, 1'b1);
        en = 1;
        tick(); chk("ar.c1", int'(count), 1);
        tick(); chk("ar.c2", int'(count), 0);
        tick(); chk("ar.reload", int'(count), 2);
        chk("ar.exp", int'(expired), 1);
        chk("ar.busy", int'(busy), 1);
        tick(); chk("ar.exp_off", int'(expired), 0);
        tick(); tick(); chk("ar.exp2", int'(expired), 1);

        // enable gating and borrow-in gating
        do_load(8'd5, 1'b0);
        en = 1; tick(); en = 0; tick(); en = 1; tick(); en = 0; tick();
        chk("en.toggle", int'(count), 3);
        do_load(8'd5, 1'b0);
        en = 1; cin = 0; tick(); tick();
        chk("cin.frozen", int'(count), 5);

        // load during a terminal step wins
        do_load(8'd0, 1'b0);
        en = 1; cin = 1;
        #1 chk("tl.bout", int'(bout), 1);
        load = 1; lv = 8'h80; tick();
        load = 0; en = 0;
        chk("tl.count", int'(count), 128);
        chk("tl.busy", int'(busy), 0);
        chk("tl.noexp", int'(expired), 0);
        clr = 1; load = 1; lv = 8'h11; tick();
        clr = 0; load = 0;
        chk("clr_vs_load", int'(count), 0);

        // async reset mid-run
        do_load(8'h37, 1'b0);
        en = 1; cin = 0;
        tick();
        rst_n = 0; cin = 1;
        #1;
        chk("arst.count", int'(count), 0);
        chk("arst.busy", int'(busy), 0);
        chk("arst.exp", int'(expired), 0);
        chk("arst.bout", int'(bout), 0);
        tick();
        rst_n = 1; idle_in(); tick();

        // two cascaded stages, both auto-reload from 1
        h_load = 1; h_lv = 8'd1; h_mode = 1;
        load = 1; lv = 8'd1; mode = 1; tick();
        h_load = 0; load = 0; h_start = 1; start = 1; tick();
        h_start = 0; start = 0; en = 1; h_en = 1; cin = 1;
        tick(); chk("cas.s1_hi", int'(h_count), 1);
        tick(); chk("cas.s2_hi", int'(h_count), 0);
        chk("cas.s2_lo", int'(count), 1);
        tick(); chk("cas.s3_hi", int'(h_count), 0);
        #1 chk("cas.s4_hbout", int'(h_bout), 1);
        tick(); chk("cas.s4_hexp", int'(h_expired), 1);
        chk("cas.s4_hi", int'(h_count), 1);

        // randomized traffic on both stages
        for (int i = 0; i < 600; i++) begin
            clr   = ($urandom_range(31) == 0);
            load  = ($urandom_range(15) == 0);
            lv    = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(4));
            start = ($urandom_range(7) == 0);
            en    = ($urandom_range(3) != 0);
            cin   = ($urandom_range(7) != 0);
            mode  = $urandom_range(1);
            h_clr   = ($urandom_range(63) == 0);
            h_load  = ($urandom_range(31) == 0);
            h_lv    = 8'($urandom_range(3));
            h_start = ($urandom_range(7) == 0);
            h_en    = ($urandom_range(7) != 0);
            h_mode  = $urandom_range(1);
            if (i == 300) begin
                #2 rst_n = 0;
                #2 rst_n = 1;
            end
            tick();
        end
        idle_in();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
